// File: rtl/otp_auth_ctrl.sv
// OTP authenticator sequencer: free-running LFSR, OTP capture, two-digit entry,
// attempt limiting with lockout, and a registered two-digit seven-segment scan.
`timescale 1ns/1ps
module otp_auth_ctrl #(
   parameter int          SCAN_DIV      = 4,
   parameter int          MAX_TRIES     = 3,
   parameter int          LOCK_CYCLES   = 16,
   parameter int          RESULT_CYCLES = 8,
   parameter logic [7:0]  LFSR_SEED     = 8'hB7
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       otp_latch,
   input  logic       user_latch,
   input  logic [3:0] user_in,
   output logic [6:0] lfsr_out,
   output logic [6:0] user_out,
   output logic [1:0] an,
   output logic       auth_ok,
   output logic       auth_fail,
   output logic       locked
);

   localparam int TW   = $clog2(MAX_TRIES + 1);
   localparam int TMAX = (LOCK_CYCLES > RESULT_CYCLES) ? LOCK_CYCLES : RESULT_CYCLES;
   localparam int CW   = $clog2(TMAX + 1);
   localparam int SW   = $clog2(SCAN_DIV);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY_HI, S_ENTRY_LO, S_CHECK, S_PASS, S_FAIL, S_LOCKOUT
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [7:0]      r_q;
   logic            r_otp_prev, r_user_prev;
   logic [7:0]      r_otp, w_otp_nxt;
   logic [3:0]      r_hi, w_hi_nxt, r_lo, w_lo_nxt;
   logic            r_hi_vld, w_hi_vld_nxt, r_lo_vld, w_lo_vld_nxt;
   logic [TW-1:0]   r_tries, w_tries_nxt, w_tries_inc;
   logic [CW-1:0]   r_timer, w_timer_nxt;
   logic [SW-1:0]   r_scan;
   logic            r_sel;
   logic [1:0]      r_an;
   logic [6:0]      r_lfsr_seg, r_user_seg, w_lfsr_seg, w_user_seg;
   logic            w_otp_rise, w_user_rise, w_lfsr_fb;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      s = 7'h7F;
      case (d)
         4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   assign w_otp_rise  = otp_latch & ~r_otp_prev;
   assign w_user_rise = user_latch & ~r_user_prev;
   assign w_lfsr_fb   = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];
   assign w_tries_inc = r_tries + TW'(1);

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_otp_nxt    = r_otp;
      w_hi_nxt     = r_hi;
      w_lo_nxt     = r_lo;
      w_hi_vld_nxt = r_hi_vld;
      w_lo_vld_nxt = r_lo_vld;
      w_tries_nxt  = r_tries;
      w_timer_nxt  = r_timer;
      case (r_state)
         S_IDLE, S_ENTRY_HI, S_ENTRY_LO, S_PASS, S_FAIL: begin
            if (w_otp_rise) begin
               w_otp_nxt    = r_q;
               w_hi_vld_nxt = 1'b0;
               w_lo_vld_nxt = 1'b0;
               w_state_nxt  = S_ENTRY_HI;
            end else if (r_state == S_ENTRY_HI && w_user_rise) begin
               w_hi_nxt     = user_in;
               w_hi_vld_nxt = 1'b1;
               w_state_nxt  = S_ENTRY_LO;
            end else if (r_state == S_ENTRY_LO && w_user_rise) begin
               w_lo_nxt     = user_in;
               w_lo_vld_nxt = 1'b1;
               w_state_nxt  = S_CHECK;
            end else if (r_state == S_PASS || r_state == S_FAIL) begin
               if (r_timer == '0) begin
                  w_state_nxt  = S_IDLE;
                  w_hi_vld_nxt = 1'b0;
                  w_lo_vld_nxt = 1'b0;
               end else begin
                  w_timer_nxt = r_timer - CW'(1);
               end
            end
         end
         S_CHECK: begin
            if ({r_hi, r_lo} == r_otp) begin
               w_state_nxt = S_PASS;
               w_tries_nxt = '0;
               w_timer_nxt = CW'(RESULT_CYCLES - 1);
            end else if (w_tries_inc == TW'(MAX_TRIES)) begin
               w_state_nxt = S_LOCKOUT;
               w_tries_nxt = '0;
               w_timer_nxt = CW'(LOCK_CYCLES - 1);
            end else begin
               w_state_nxt = S_FAIL;
               w_tries_nxt = w_tries_inc;
               w_timer_nxt = CW'(RESULT_CYCLES - 1);
            end
         end
         S_LOCKOUT: begin
            if (r_timer == '0) begin
               w_state_nxt  = S_IDLE;
               w_hi_vld_nxt = 1'b0;
               w_lo_vld_nxt = 1'b0;
            end else begin
               w_timer_nxt = r_timer - CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // sel=0 drives an[0] low, so it shows the low nibble.
   always_comb begin
      w_lfsr_seg = 7'h7F;
      w_user_seg = 7'h7F;
      if (r_state != S_IDLE && r_state != S_LOCKOUT)
         w_lfsr_seg = seg7(r_sel ? r_otp[7:4] : r_otp[3:0]);
      if (r_sel && r_hi_vld)
         w_user_seg = seg7(r_hi);
      else if (!r_sel && r_lo_vld)
         w_user_seg = seg7(r_lo);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_q         <= LFSR_SEED;
         r_otp_prev  <= 1'b0;
         r_user_prev <= 1'b0;
         r_otp       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_hi_vld    <= 1'b0;
         r_lo_vld    <= 1'b0;
         r_tries     <= '0;
         r_timer     <= '0;
         r_scan      <= '0;
         r_sel       <= 1'b0;
         r_an        <= 2'b11;
         r_lfsr_seg  <= 7'h7F;
         r_user_seg  <= 7'h7F;
      end else begin
         r_state     <= w_state_nxt;
         r_q         <= {r_q[6:0], w_lfsr_fb};
         r_otp_prev  <= otp_latch;
         r_user_prev <= user_latch;
         r_otp       <= w_otp_nxt;
         r_hi        <= w_hi_nxt;
         r_lo        <= w_lo_nxt;
         r_hi_vld    <= w_hi_vld_nxt;
         r_lo_vld    <= w_lo_vld_nxt;
         r_tries     <= w_tries_nxt;
         r_timer     <= w_timer_nxt;
         if (r_scan == SW'(SCAN_DIV - 1)) begin
            r_scan <= '0;
            r_sel  <= ~r_sel;
         end else begin
            r_scan <= r_scan + SW'(1);
         end
         r_an       <= r_sel ? 2'b01 : 2'b10;
         r_lfsr_seg <= w_lfsr_seg;
         r_user_seg <= w_user_seg;
      end
   end

   assign lfsr_out  = r_lfsr_seg;
   assign user_out  = r_user_seg;
   assign an        = r_an;
   assign auth_ok   = (r_state == S_PASS);
   assign auth_fail = (r_state == S_FAIL);
   assign locked    = (r_state == S_LOCKOUT);

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Self-checking bench for otp_auth_ctrl: scenario tasks with a result scoreboard
// and a reference LFSR that predicts each captured OTP.
`timescale 1ns/1ps
module tb_otp_auth_ctrl;

   typedef enum int {R_PASS, R_FAIL, R_LOCK} res_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       otp_latch = 1'b0;
   logic       user_latch = 1'b0;
   logic [3:0] user_in = 4'h0;
   logic [6:0] lfsr_out, user_out;
   logic [1:0] an;
   logic       auth_ok, auth_fail, locked;

   int   tot = 0;
   int   bad = 0;
   res_t exp_q[$];
   logic [7:0] m_q;

   otp_auth_ctrl #(
      .SCAN_DIV(4), .MAX_TRIES(3), .LOCK_CYCLES(16), .RESULT_CYCLES(8), .LFSR_SEED(8'hB7)
   ) dut (
      .clk(clk), .reset_n(reset_n), .otp_latch(otp_latch), .user_latch(user_latch),
      .user_in(user_in), .lfsr_out(lfsr_out), .user_out(user_out), .an(an),
      .auth_ok(auth_ok), .auth_fail(auth_fail), .locked(locked)
   );

   always #5 clk = ~clk;

   // Reference LFSR: value the DUT holds between rising edges.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m_q <= 8'hB7;
      else          m_q <= {m_q[6:0], m_q[7] ^ m_q[5] ^ m_q[4] ^ m_q[3]};
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic capture(output logic [7:0] o);
      o = m_q;
      otp_latch = 1'b1;
      @(negedge clk);
      otp_latch = 1'b0;
      @(negedge clk);
   endtask

   task automatic press_user(input logic [3:0] d);
      user_in = d;
      user_latch = 1'b1;
      @(negedge clk);
      user_latch = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_result();
      int   n;
      int   dur;
      int   want_dur;
      res_t got;
      res_t exp_r;
      n = 0;
      while (!(auth_ok || auth_fail || locked) && n < 10) begin
         @(negedge clk);
         n++;
      end
      tot++;
      if (!(auth_ok || auth_fail || locked)) begin
         bad++;
         $display("FAIL result_timeout: no flag after %0d cycles, want one", n);
         if (exp_q.size() > 0) exp_q.delete(0);
         return;
      end
      got = locked ? R_LOCK : (auth_fail ? R_FAIL : R_PASS);
      exp_r = (exp_q.size() > 0) ? exp_q.pop_front() : R_PASS;
      if (got !== exp_r) begin
         bad++;
         $display("FAIL result_kind: got %s want %s", got.name(), exp_r.name());
      end
      tot++;
      if (n !== 1) begin
         bad++;
         $display("FAIL result_latency: got %0d want 1", n);
      end
      dur = 0;
      while (((got == R_PASS) ? auth_ok : (got == R_FAIL) ? auth_fail : locked) && dur < 40) begin
         otp_latch = (got == R_LOCK && dur < 10) ? dur[0] : 1'b0;
         dur++;
         @(negedge clk);
      end
      otp_latch = 1'b0;
      want_dur = (got == R_LOCK) ? 16 : 8;
      tot++;
      if (dur !== want_dur) begin
         bad++;
         $display("FAIL result_duration(%s): got %0d want %0d", got.name(), dur, want_dur);
      end
      tick(1);
      tot++;
      if (lfsr_out !== 7'h7F) begin
         bad++;
         $display("FAIL idle_lfsr_blank: got %h want 7f", lfsr_out);
      end
      tot++;
      if (user_out !== 7'h7F) begin
         bad++;
         $display("FAIL idle_user_blank: got %h want 7f", user_out);
      end
   endtask

   task automatic enter_code(input logic [7:0] code, input res_t exp_r);
      press_user(code[7:4]);
      user_in = code[3:0];
      user_latch = 1'b1;
      exp_q.push_back(exp_r);
      @(negedge clk);
      user_latch = 1'b0;
      tot++;
      if ({auth_ok, auth_fail, locked} !== 3'b000) begin
         bad++;
         $display("FAIL check_flags: got %b want 000", {auth_ok, auth_fail, locked});
      end
      wait_result();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(2);
      tot++;
      if ({lfsr_out, user_out, an, auth_ok, auth_fail, locked} !== {7'h7F, 7'h7F, 2'b11, 3'b000}) begin
         bad++;
         $display("FAIL reset_outputs: got %h/%h/%b/%b want 7f/7f/11/000",
                  lfsr_out, user_out, an, {auth_ok, auth_fail, locked});
      end
      reset_n = 1'b1;
      tick(1);
      tot++;
      if (an !== 2'b10) begin
         bad++;
         $display("FAIL first_an: got %b want 10", an);
      end
   endtask

   task automatic test_lfsr();
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      tot++;
      if (dut.r_q !== 8'hB7) begin bad++; $display("FAIL lfsr_step0: got %h want b7", dut.r_q); end
      tick(1);
      tot++;
      if (dut.r_q !== 8'h6F) begin bad++; $display("FAIL lfsr_step1: got %h want 6f", dut.r_q); end
      tick(1);
      tot++;
      if (dut.r_q !== 8'hDE) begin bad++; $display("FAIL lfsr_step2: got %h want de", dut.r_q); end
      tick(253);
      tot++;
      if (dut.r_q !== 8'hB7) begin bad++; $display("FAIL lfsr_period: got %h want b7", dut.r_q); end
   endtask

   task automatic test_pass_and_display();
      int         k;
      int         run;
      int         changes;
      logic [1:0] prev_an;
      logic [7:0] o;
      k = 0;
      while (m_q !== 8'h5A && k < 300) begin
         @(negedge clk);
         k++;
      end
      capture(o);
      tot++;
      if (o !== 8'h5A) begin bad++; $display("FAIL otp_search: got %h want 5a", o); end
      prev_an = an;
      run = 1;
      changes = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         tot++;
         if (!((an === 2'b10 && lfsr_out === 7'b0001000) || (an === 2'b01 && lfsr_out === 7'b0010010))) begin
            bad++;
            $display("FAIL disp_otp: an=%b lfsr_out=%b want 10/0001000 or 01/0010010", an, lfsr_out);
         end
         tot++;
         if (user_out !== 7'h7F) begin bad++; $display("FAIL disp_user_blank: got %h want 7f", user_out); end
         if (an === prev_an) begin
            run++;
         end else begin
            if (changes > 0) begin
               tot++;
               if (run !== 4) begin bad++; $display("FAIL scan_period: got %0d want 4", run); end
            end
            changes++;
            run = 1;
            prev_an = an;
         end
      end
      tot++;
      if (changes < 3) begin bad++; $display("FAIL scan_toggles: got %0d want >=3", changes); end
      press_user(4'h5);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tot++;
         if (user_out !== ((an === 2'b01) ? 7'b0010010 : 7'h7F)) begin
            bad++;
            $display("FAIL disp_user_hi: an=%b got %b", an, user_out);
         end
      end
      user_in = 4'hA;
      user_latch = 1'b1;
      exp_q.push_back(R_PASS);
      @(negedge clk);
      user_latch = 1'b0;
      wait_result();
   endtask

   task automatic test_lockout();
      logic [7:0] o;
      for (int i = 0; i < 3; i++) begin
         capture(o);
         enter_code(o ^ 8'hFF, (i == 2) ? R_LOCK : R_FAIL);
      end
      tick(3);
      tot++;
      if ({lfsr_out, auth_ok, auth_fail, locked} !== {7'h7F, 3'b000}) begin
         bad++;
         $display("FAIL post_lock_idle: got %h/%b want 7f/000", lfsr_out, {auth_ok, auth_fail, locked});
      end
      capture(o);
      enter_code(o ^ 8'h0F, R_FAIL);
   endtask

   task automatic test_preempt();
      logic [7:0] o1;
      logic [7:0] o2;
      capture(o1);
      press_user(o1[7:4]);
      capture(o2);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tot++;
         if (user_out !== 7'h7F) begin bad++; $display("FAIL preempt_user_blank: got %h want 7f", user_out); end
      end
      enter_code(o2 ^ 8'hF0, R_FAIL);
      capture(o1);
      press_user(o1[7:4]);
      capture(o2);
      enter_code(o2, R_PASS);
   endtask

   task automatic test_back_to_back();
      logic [7:0] o1;
      logic [7:0] o2;
      capture(o1);
      o2 = m_q;
      user_in = ~o1[7:4];
      otp_latch = 1'b1;
      user_latch = 1'b1;
      @(negedge clk);
      otp_latch = 1'b0;
      user_latch = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tot++;
         if (user_out !== 7'h7F) begin bad++; $display("FAIL simul_hi_dropped: got %h want 7f", user_out); end
      end
      enter_code(o2, R_PASS);
   endtask

   task automatic test_mid_reset();
      logic [7:0] o;
      capture(o);
      press_user(o[7:4]);
      tick(3);
      #2 reset_n = 1'b0;
      #1;
      tot++;
      if ({lfsr_out, user_out, an, auth_ok, auth_fail, locked} !== {7'h7F, 7'h7F, 2'b11, 3'b000}) begin
         bad++;
         $display("FAIL async_reset: got %h/%h/%b/%b want 7f/7f/11/000",
                  lfsr_out, user_out, an, {auth_ok, auth_fail, locked});
      end
      @(negedge clk);
      reset_n = 1'b1;
      user_in = o[3:0];
      user_latch = 1'b1;
      @(negedge clk);
      user_latch = 1'b0;
      tick(2);
      tot++;
      if ({lfsr_out, auth_ok, auth_fail, locked} !== {7'h7F, 3'b000}) begin
         bad++;
         $display("FAIL post_reset_idle: got %h/%b want 7f/000", lfsr_out, {auth_ok, auth_fail, locked});
      end
   endtask

   initial begin
      test_reset();
      test_lfsr();
      test_pass_and_display();
      test_lockout();
      test_preempt();
      test_back_to_back();
      test_mid_reset();
      tot++;
      if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule

// File: doc/otp_auth_ctrl.md
# otp_auth_ctrl

Sequencing controller for the OTP authenticator. It owns the free-running 8-bit LFSR and captures a two-hex-digit one-time password on `otp_latch`. It collects two user nibbles on `user_latch`, compares them against the OTP, and enforces an attempt limit with lockout. It also time-multiplexes the two-digit seven-segment display (`lfsr_out`, `user_out`, `an`) that the agents on the OTP interface observe.

## Interface
- `SCAN_DIV`, 4: cycles per display digit before `an` toggles (≥2).
- `MAX_TRIES`, 3: consecutive failed checks that trigger lockout (≥1).
- `LOCK_CYCLES`, 16: cycles spent in LOCKOUT.
- `RESULT_CYCLES`, 8: cycles spent in PASS or FAIL.
- `LFSR_SEED`, 8'hB7: LFSR reset value (nonzero).
- `clk` in 1: single clock; everything is rising-edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `otp_latch` in 1: level from button; its rising edge requests a new OTP.
- `user_latch` in 1: level from button; its rising edge enters `user_in`.
- `user_in` in 4: user hex digit.
- `lfsr_out` out 7: OTP segments `{g,f,e,d,c,b,a}`, active-low.
- `user_out` out 7: entered-digit segments, same encoding.
- `an` out 2: digit enables, active-low; `an[0]` is the low nibble, `an[1]` is the high nibble.
- `auth_ok` out 1: high in PASS.
- `auth_fail` out 1: high in FAIL.
- `locked` out 1: high in LOCKOUT.

## Operation
- **LFSR.** 8-bit Fibonacci register, shifts every cycle in all states.
  - Feedback: `nb = q[7]^q[5]^q[4]^q[3]`; next `q = {q[6:0], nb}`.
  - Period is 255.
- **Edge detect.** Registered copies of both latch inputs, reset to 0; `rise = in & ~prev`.
- **States:** IDLE, ENTRY_HI, ENTRY_LO, CHECK, PASS, FAIL, LOCKOUT.
- **OTP capture.** A rise on `otp_latch` in IDLE, ENTRY_HI, ENTRY_LO, PASS or FAIL does all of the following:
  - `otp` gets the current `q`.
  - Entered digits are cleared.
  - The FSM goes to ENTRY_HI.
  - No try is consumed.
- **ENTRY_HI.** A `user_latch` rise stores `hi = user_in` and moves to ENTRY_LO.
- **ENTRY_LO.** A `user_latch` rise stores `lo = user_in` and moves to CHECK.
- **CHECK** (1 cycle):
  - `{hi,lo}==otp`: go to PASS and clear `tries`.
  - Else, if `tries+1==MAX_TRIES`: go to LOCKOUT and clear `tries`.
  - Else: `tries++` and go to FAIL.
- **PASS/FAIL.** Stay exactly RESULT_CYCLES cycles, then go to IDLE. `tries` persists across FAIL→IDLE.
- **LOCKOUT.** Stay exactly LOCK_CYCLES cycles, then go to IDLE. Both latch inputs are ignored; edge registers still track.
- **Simultaneous rises.** `otp_latch` wins; the `user_latch` rise is dropped.
- **Ignored latches.** `user_latch` is ignored in IDLE, CHECK, PASS, FAIL and LOCKOUT.
- **Display scan.**
  - Free-running counter; `sel` toggles every SCAN_DIV cycles.
  - `sel=0` gives `an=2'b10`; `sel=1` gives `an=2'b01`.
- **`lfsr_out`:**
  - ENTRY_HI through FAIL: the selected OTP nibble.
  - IDLE and LOCKOUT: blank, 7'h7F.
- **`user_out`:**
  - Shows the selected entered nibble if that nibble has been entered in the current attempt; otherwise blank.
  - Holds its digits through CHECK, PASS and FAIL; cleared on entering IDLE.
- **Segment encoding.** Standard hex 0–F, e.g. 0=7'b1000000, 5=7'b0010010, A=7'b0001000, F=7'b0001110.
- **Status flags.** `auth_ok`, `auth_fail` and `locked` decode directly from the state register, so they are glitch-free.

## Timing
- **Reset (asynchronous) sets:**
  - State IDLE, `q=LFSR_SEED`, `tries=0`, scan counter 0, `sel=0`.
  - `lfsr_out=user_out=7'h7F`, `an=2'b11`.
  - `auth_ok=auth_fail=locked=0`.
- **Reset mid-operation.** Aborts immediately with no completion of the pending check.
- **Capture latency.** `otp_latch` is first sampled high at edge n:
  - The captured OTP is `q` as it stood before edge n.
  - The state is ENTRY_HI after edge n.
- **Digit entry.**
  - The second digit sampled at edge m puts the FSM in CHECK after edge m.
  - PASS, FAIL or LOCKOUT follows after edge m+1, and the flag is high from then on.
- **Segment outputs.** `lfsr_out`, `user_out` and `an` are registered and reflect the state and `sel` of the previous cycle.
  - First cycle after reset release: `an=2'b10`.
- **Held latches.** A latch input held high produces exactly one event.

## Test plan
- **LFSR:** reset with seed B7, release → `q` steps B7, 6F, DE; returns to B7 after 255 shifts.
- **Pass:** `otp_latch` captures 8'h5A; `user_in` 5 then A on `user_latch` rises → `auth_ok` high exactly 8 cycles, then IDLE, `lfsr_out=7'h7F`.
- **Display** with OTP 5A, SCAN_DIV=4:
  - `an` alternates 10/01 every 4 cycles.
  - `lfsr_out` shows 7'b0001000 with `an=10` and 7'b0010010 with `an=01`.
  - `user_out` is blank until digits are entered.
- **Lockout:** three wrong entries → FAIL, FAIL, then LOCKOUT.
  - `locked` is high 16 cycles.
  - `otp_latch` pulses during lockout are ignored.
  - Afterwards the FSM is in IDLE with `tries=0`.
- **Preemption:**
  - `otp_latch` rise in ENTRY_LO → new OTP captured, `user_out` blank, no try consumed.
  - Simultaneous `otp_latch` and `user_latch` rises in ENTRY_HI → `hi` not stored.
- **Reset:** assert `reset_n` low in ENTRY_LO → outputs go to the reset values immediately, without waiting for a clock; after release the FSM is in IDLE with `auth_*` and `locked` low.
